mc_maindec: RTL

- Multicycle main control FSM for the MIPS core.
- Sequences each instruction through fetch, decode, execute, memory and writeback. Emits the per-cycle datapath control word, including the 2-bit aluop consumed directly by the ALU decoder.
- Sits between the instruction register (opcode source) and the ALU decoder and datapath muxes. Stalls on a memory-ready handshake.

---
 rtl/mips_ctrl_pkg.sv | 53 +++++
 rtl/mc_ctrl_outdec.sv | 76 +++++++
 rtl/mc_maindec.sv | 87 ++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM states,
// ALU/mux select codes and the packed control word.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTYPEEX = 4'd6;
  localparam logic [3:0] S_RTYPEWB = 4'd7;
  localparam logic [3:0] S_BEQEX   = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JEX     = 4'd11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_REG   = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALURES = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_word_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational state -> control word decode, including mem_ready handshake
// gating in FETCH and suppression of all write strobes while reset is held.
module mc_ctrl_outdec
  import mips_ctrl_pkg::*;
#(
  parameter int SW_STATE = 4
) (
  input  logic [SW_STATE-1:0] state,
  input  logic                mem_ready,
  input  logic                reset,
  output ctrl_word_t          cw
);

  always_comb begin
    cw = '0;
    case (state)
      S_FETCH: begin
        cw.alusrcb = ALUSRCB_FOUR;
        cw.aluop   = ALUOP_ADD;
        cw.pcsrc   = PCSRC_ALURES;
        cw.irwrite = mem_ready;
        cw.pcwrite = mem_ready;
      end
      S_DECODE: begin
        cw.alusrcb = ALUSRCB_IMMSH;
        cw.aluop   = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = ALUSRCB_IMM;
        cw.aluop   = ALUOP_ADD;
      end
      S_MEMRD: cw.iord = 1'b1;
      S_MEMWB: begin
        cw.regwrite = 1'b1;
        cw.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        cw.iord     = 1'b1;
        cw.memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = ALUSRCB_REG;
        cw.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        cw.regwrite = 1'b1;
        cw.regdst   = 1'b1;
      end
      S_BEQEX: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = ALUSRCB_REG;
        cw.aluop   = ALUOP_SUB;
        cw.pcsrc   = PCSRC_ALUOUT;
        cw.branch  = 1'b1;
      end
      S_ADDIWB: cw.regwrite = 1'b1;
      S_JEX: begin
        cw.pcsrc   = PCSRC_JUMP;
        cw.pcwrite = 1'b1;
      end
      default: cw = '0;
    endcase

    // Reset is asynchronous, so strobes must drop in the very cycle it rises.
    if (reset) begin
      cw.pcwrite  = 1'b0;
      cw.branch   = 1'b0;
      cw.memwrite = 1'b0;
      cw.irwrite  = 1'b0;
      cw.regwrite = 1'b0;
    end
  end

endmodule

// File: rtl/mc_maindec.sv
// Multicycle MIPS main control FSM: state register, opcode-driven next-state
// logic and PC write enable; the per-state control word comes from mc_ctrl_outdec.
module mc_maindec
  import mips_ctrl_pkg::*;
#(
  parameter int OPW      = 6,
  parameter int SW_STATE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPW-1:0]      op,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pcen,
  output logic                memwrite,
  output logic                irwrite,
  output logic                regwrite,
  output logic                iord,
  output logic                memtoreg,
  output logic                regdst,
  output logic                alusrca,
  output logic [1:0]          alusrcb,
  output logic [1:0]          pcsrc,
  output logic [1:0]          aluop,
  output logic [SW_STATE-1:0] state_o
);

  logic [SW_STATE-1:0] state_q;
  logic [SW_STATE-1:0] state_d;
  ctrl_word_t          cw;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (mem_ready) state_d = SW_STATE'(S_DECODE);
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = SW_STATE'(S_MEMADR);
          OP_RTYPE:     state_d = SW_STATE'(S_RTYPEEX);
          OP_BEQ:       state_d = SW_STATE'(S_BEQEX);
          OP_ADDI:      state_d = SW_STATE'(S_ADDIEX);
          OP_J:         state_d = SW_STATE'(S_JEX);
          default:      state_d = SW_STATE'(S_FETCH);
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW)      state_d = SW_STATE'(S_MEMRD);
        else if (op == OP_SW) state_d = SW_STATE'(S_MEMWR);
        else                  state_d = SW_STATE'(S_FETCH);
      end
      S_MEMRD:   if (mem_ready) state_d = SW_STATE'(S_MEMWB);
      S_MEMWR:   if (mem_ready) state_d = SW_STATE'(S_FETCH);
      S_RTYPEEX: state_d = SW_STATE'(S_RTYPEWB);
      S_ADDIEX:  state_d = SW_STATE'(S_ADDIWB);
      // Single-cycle tails and the illegal encodings all return to FETCH.
      default:   state_d = SW_STATE'(S_FETCH);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= SW_STATE'(S_FETCH);
    else       state_q <= state_d;
  end

  mc_ctrl_outdec #(
    .SW_STATE (SW_STATE)
  ) u_outdec (
    .state     (state_q),
    .mem_ready (mem_ready),
    .reset     (reset),
    .cw        (cw)
  );

  assign pcen     = cw.pcwrite | (cw.branch & zero);
  assign memwrite = cw.memwrite;
  assign irwrite  = cw.irwrite;
  assign regwrite = cw.regwrite;
  assign iord     = cw.iord;
  assign memtoreg = cw.memtoreg;
  assign regdst   = cw.regdst;
  assign alusrca  = cw.alusrca;
  assign alusrcb  = cw.alusrcb;
  assign pcsrc    = cw.pcsrc;
  assign aluop    = cw.aluop;
  assign state_o  = state_q;

endmodule
